// File: rtl/rsa_pkg.sv
// Shared types and constants for the Montgomery constant generator.
// RSA_CONST_GEN_RADIX4_EN selects two reduction steps per clock, which halves the iteration count.
package rsa_pkg;

  localparam int RSA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } const_gen_state_t;

  function automatic int const_gen_iters(input int width);
`ifdef RSA_CONST_GEN_RADIX4_EN
    return width;
`else
    return 2 * width;
`endif
  endfunction

endpackage

// File: rtl/rsa_const_step.sv
// One combinational double-and-subtract step: r' = 2r mod p, valid while r < p.
// Zero latency; no flow control.
module rsa_const_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH:0]   r_next
);

  logic [WIDTH:0] t;
  logic [WIDTH:0] p_ext;

  // Because r < p, 2r < 2p, so a single conditional subtract is enough.
  always_comb begin
    t      = r << 1;
    p_ext  = {1'b0, p};
    r_next = (t >= p_ext) ? (t - p_ext) : t;
  end

endmodule

// File: rtl/rsa_const_gen.sv
// Computes Const = 2^(2*WIDTH) mod P by iterated doubling. Done arrives 2*WIDTH+1 clocks after start.
// With RSA_CONST_GEN_RADIX4_EN it arrives WIDTH+1 clocks after start. ena stalls all state; start is ignored while busy.
module rsa_const_gen
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] p_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             const_valid,
  output logic [WIDTH-1:0] const_out
);

  localparam int            CW    = $clog2(2 * WIDTH) + 1;
  localparam int            ITERS = const_gen_iters(WIDTH);
  localparam logic [CW-1:0] LAST  = CW'(ITERS - 1);

  const_gen_state_t state, state_nxt;

  logic [WIDTH-1:0] p_q;
  logic [WIDTH:0]   r;
  logic [WIDTH:0]   r_step;
  logic [CW-1:0]    cnt;
  logic             p_bad;

  // Montgomery needs an odd modulus; 1 gives a meaningless constant.
  assign p_bad = ~p_in[0] || (p_in < WIDTH'(3));

`ifdef RSA_CONST_GEN_RADIX4_EN
  logic [WIDTH:0] r_mid;

  rsa_const_step #(.WIDTH(WIDTH)) u_step0 (.r(r),     .p(p_q), .r_next(r_mid));
  rsa_const_step #(.WIDTH(WIDTH)) u_step1 (.r(r_mid), .p(p_q), .r_next(r_step));
`else
  rsa_const_step #(.WIDTH(WIDTH)) u_step0 (.r(r), .p(p_q), .r_next(r_step));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state == CALC);
    done      = (state == DONE);
    if (ena) begin
      if (clear) begin
        state_nxt = IDLE;
      end else begin
        case (state)
          IDLE:    if (start) state_nxt = p_bad ? DONE : CALC;
          CALC:    if (cnt == LAST) state_nxt = DONE;
          DONE:    state_nxt = IDLE;
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q         <= '0;
      r           <= '0;
      cnt         <= '0;
      err         <= 1'b0;
      const_valid <= 1'b0;
      const_out   <= '0;
    end else if (ena) begin
      if (clear) begin
        // const_out is left as-is but no longer marked valid.
        err         <= 1'b0;
        const_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              p_q         <= p_in;
              const_valid <= 1'b0;
              err         <= 1'b0;
              if (p_bad) begin
                err       <= 1'b1;
                const_out <= '0;
              end else begin
                r   <= (WIDTH + 1)'(1);
                cnt <= '0;
              end
            end
          end
          CALC: begin
            r   <= r_step;
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
              const_out   <= r_step[WIDTH-1:0];
              const_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
